// File: rtl/stim_seq_multich_if.sv
// stim_seq_multich_if
// Groups the stimulus sequencer's control inputs and its ST analog drive
// outputs into one bundle.
//   master : the sequencer (takes the controls, drives the ST outputs)
//   slave  : whoever commands the sequencer and watches its outputs
// Signals:
//   enable, ramping, ch_sweeping  level controls for the stimulus train
//   mag_target                    requested magnitude code
//   EN_ST, CAT_ST, ANO_ST, DIS_ST stimulator enable and phase controls
//   CH_SEL_U_ST, CH_SEL_D_ST      upper/lower electrode selects
//   MAG_ST                        magnitude code in use
//   BLANK_EMG                     EMG blanking window
//   pulse_done                    strobe on the last discharge cycle
interface stim_seq_multich_if #(
  parameter int CH_W  = 2,
  parameter int MAG_W = 5
);
  logic             enable;
  logic             ramping;
  logic             ch_sweeping;
  logic [MAG_W-1:0] mag_target;
  logic             EN_ST;
  logic             CAT_ST;
  logic             ANO_ST;
  logic             DIS_ST;
  logic [CH_W-1:0]  CH_SEL_U_ST;
  logic [CH_W-1:0]  CH_SEL_D_ST;
  logic [MAG_W-1:0] MAG_ST;
  logic             BLANK_EMG;
  logic             pulse_done;

  modport master (
    input  enable, ramping, ch_sweeping, mag_target,
    output EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_U_ST, CH_SEL_D_ST,
           MAG_ST, BLANK_EMG, pulse_done
  );

  modport slave (
    output enable, ramping, ch_sweeping, mag_target,
    input  EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_U_ST, CH_SEL_D_ST,
           MAG_ST, BLANK_EMG, pulse_done
  );
endinterface

// File: rtl/stim_seq_multich.sv
// stim_seq_multich
// Biphasic stimulus sequencer for the ST channel array. Each period runs
// cathodic -> inter-pulse delay -> anodic -> delay -> discharge -> rest,
// timed by one period counter. Magnitude ramping and channel sweeping are
// applied only at pulse starts, so a pulse is never altered once it begins.
// Ports:
//   clk     system clock, rising edge
//   Resetn  synchronous active-low reset
//   bus     stim_seq_multich_if.master (controls in, ST drive out)
module stim_seq_multich #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int MAG_W         = 5,
  parameter int CNT_W         = 16,
  parameter int PERIOD        = 500,
  parameter int CAT_PH        = 150,
  parameter int IPD           = 10,
  parameter int ANO_PH        = 150,
  parameter int DIS_DLY       = 1,
  parameter int DIS_PH        = 5,
  parameter int BLANK_TAIL    = 20,
  parameter int PULSES_PER_CH = 5,
  parameter int RAMP_STEP     = 1
) (
  input logic                clk,
  input logic                Resetn,
  stim_seq_multich_if.master bus
);

  // Last pc value of each phase; a zero-length phase ends on the same pc as
  // the one before it and is skipped by the next-state logic.
  localparam logic [CNT_W-1:0] CAT_END   = CNT_W'(CAT_PH - 1);
  localparam logic [CNT_W-1:0] IPD_END   = CNT_W'(CAT_PH + IPD - 1);
  localparam logic [CNT_W-1:0] ANO_END   = CNT_W'(CAT_PH + IPD + ANO_PH - 1);
  localparam logic [CNT_W-1:0] DLY_END   = CNT_W'(CAT_PH + IPD + ANO_PH + DIS_DLY - 1);
  localparam logic [CNT_W-1:0] DIS_END   = CNT_W'(CAT_PH + IPD + ANO_PH + DIS_DLY + DIS_PH - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(CAT_PH + IPD + ANO_PH + DIS_DLY + DIS_PH
                                                  + BLANK_TAIL - 1);
  localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(PERIOD - 1);
  localparam int               PCNT_W    = $clog2(PULSES_PER_CH + 1);
  localparam logic [PCNT_W-1:0] PPC      = PCNT_W'(PULSES_PER_CH);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAT, S_IPD, S_ANO, S_DLY, S_DIS, S_REST
  } state_t;

  state_t            state_q, state_d, period_next;
  logic [CNT_W-1:0]  pc_q;
  logic [MAG_W-1:0]  mag_q, mag_next;
  logic [MAG_W:0]    mag_sum;
  logic [CH_W-1:0]   ch_idx_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              start_pulse, restart, to_idle, dis_last, advance_ch;
  logic              en_d, cat_d, ano_d, dis_d, blank_d, done_d;
  logic              en_q, cat_q, ano_q, dis_q, blank_q, done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // At the end of a period the train continues only while enable is high.
  assign period_next = bus.enable ? S_CAT : S_IDLE;

  // Next-state logic; DIS goes straight to the period end if no rest remains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.enable)        state_d = S_CAT;
      S_CAT:  if (pc_q == CAT_END)   state_d = (IPD == 0) ? S_ANO : S_IPD;
      S_IPD:  if (pc_q == IPD_END)   state_d = S_ANO;
      S_ANO:  if (pc_q == ANO_END)   state_d = (DIS_DLY == 0) ? S_DIS : S_DLY;
      S_DLY:  if (pc_q == DLY_END)   state_d = S_DIS;
      S_DIS:  if (pc_q == DIS_END)   state_d = (DIS_END == PC_LAST) ? period_next : S_REST;
      S_REST: if (pc_q == PC_LAST)   state_d = period_next;
      default:                       state_d = S_IDLE;
    endcase
  end

  assign start_pulse = (state_d == S_CAT) && (state_q != S_CAT);
  assign restart     = start_pulse && (state_q != S_IDLE);
  assign to_idle     = (state_d == S_IDLE) && (state_q != S_IDLE);
  assign dis_last    = (state_q == S_DIS) && (pc_q == DIS_END);
  assign advance_ch  = restart && bus.ch_sweeping && (pcnt_q == PPC);

  // Ramped magnitude; the extra sum bit keeps the step from wrapping.
  always_comb begin
    mag_sum  = {1'b0, mag_q} + (MAG_W + 1)'(RAMP_STEP);
    mag_next = bus.mag_target;
    if (bus.ramping && (mag_q < bus.mag_target) && (mag_sum < {1'b0, bus.mag_target}))
      mag_next = mag_sum[MAG_W-1:0];
  end

  // Period counter, magnitude, channel index and pulse count. The channel
  // index survives a return to IDLE; the magnitude restarts from 0.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      pc_q     <= '0;
      mag_q    <= '0;
      ch_idx_q <= '0;
      pcnt_q   <= '0;
    end else begin
      if ((state_d == S_IDLE) || start_pulse) pc_q <= '0;
      else                                    pc_q <= pc_q + 1'b1;

      if (start_pulse)  mag_q <= mag_next;
      else if (to_idle) mag_q <= '0;

      if (advance_ch) begin
        ch_idx_q <= (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + 1'b1;
        pcnt_q   <= '0;
      end else if (dis_last && (pcnt_q != PPC)) begin
        pcnt_q   <= pcnt_q + 1'b1;
      end
    end
  end

  // Output decode of the current state, registered below.
  always_comb begin
    en_d    = (state_q != S_IDLE);
    cat_d   = (state_q == S_CAT);
    ano_d   = (state_q == S_ANO);
    dis_d   = (state_q == S_DIS);
    blank_d = en_d && (pc_q <= BLANK_END);
    done_d  = dis_last;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      en_q    <= 1'b0;
      cat_q   <= 1'b0;
      ano_q   <= 1'b0;
      dis_q   <= 1'b0;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      cat_q   <= cat_d;
      ano_q   <= ano_d;
      dis_q   <= dis_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign bus.EN_ST       = en_q;
  assign bus.CAT_ST      = cat_q;
  assign bus.ANO_ST      = ano_q;
  assign bus.DIS_ST      = dis_q;
  assign bus.BLANK_EMG   = blank_q;
  assign bus.pulse_done  = done_q;
  assign bus.MAG_ST      = mag_q;
  assign bus.CH_SEL_U_ST = ch_idx_q;
  assign bus.CH_SEL_D_ST = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + 1'b1;

endmodule

// File: tb/tb_stim_seq_multich.sv
// tb_stim_seq_multich
// Drives two sequencers (default timing, and a short period with IPD and
// DIS_DLY of zero) from the same random stimulus and compares every cycle
// against a timeline model: each pulse is a position within the period, and
// phase outputs are interval tests on that position.
module tb_stim_seq_multich;

  typedef struct {
    int period; int cat; int ipd; int ano; int dly; int dis; int tail;
    int ppc; int nch; int step;
  } cfg_t;

  typedef struct {
    bit running; int pos; int mag; int ch; int pcnt;
    bit o_running; int o_pos;
  } mdl_t;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       enable, ramping, ch_sweeping;
  logic [4:0] mag_target;
  int         checks = 0;
  int         errors = 0;
  cfg_t       cfg_a, cfg_b;
  mdl_t       mdl_a, mdl_b;

  stim_seq_multich_if #(.CH_W(2), .MAG_W(5)) bus_a ();
  stim_seq_multich_if #(.CH_W(2), .MAG_W(5)) bus_b ();

  assign bus_a.enable = enable;      assign bus_b.enable = enable;
  assign bus_a.ramping = ramping;    assign bus_b.ramping = ramping;
  assign bus_a.ch_sweeping = ch_sweeping; assign bus_b.ch_sweeping = ch_sweeping;
  assign bus_a.mag_target = mag_target;   assign bus_b.mag_target = mag_target;

  stim_seq_multich dut_a (.clk(clk), .Resetn(Resetn), .bus(bus_a));

  stim_seq_multich #(
    .NUM_CH(3), .CH_W(2), .MAG_W(5), .CNT_W(8), .PERIOD(40), .CAT_PH(6),
    .IPD(0), .ANO_PH(6), .DIS_DLY(0), .DIS_PH(3), .BLANK_TAIL(4),
    .PULSES_PER_CH(2), .RAMP_STEP(3)
  ) dut_b (.clk(clk), .Resetn(Resetn), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m.running = 0; m.pos = 0; m.mag = 0; m.ch = 0; m.pcnt = 0;
    m.o_running = 0; m.o_pos = 0;
    return m;
  endfunction

  // One clock edge of the reference timeline, using the inputs sampled there.
  function automatic mdl_t model_step(input cfg_t c, input mdl_t m);
    mdl_t n = m;
    int   dis_end = c.cat + c.ipd + c.ano + c.dly + c.dis - 1;
    int   tgt = int'(mag_target);
    if (!Resetn) return mdl_clear();
    n.o_running = m.running;
    n.o_pos     = m.pos;
    if (m.running && m.pos == dis_end && m.pcnt < c.ppc) n.pcnt = m.pcnt + 1;
    if (!m.running || m.pos == c.period - 1) begin
      n.pos = 0;
      if (enable) begin
        n.running = 1;
        if (!ramping || m.mag >= tgt) n.mag = tgt;
        else n.mag = (m.mag + c.step > tgt) ? tgt : m.mag + c.step;
        if (m.running && ch_sweeping && m.pcnt >= c.ppc) begin
          n.ch = (m.ch + 1) % c.nch;
          n.pcnt = 0;
        end
      end else begin
        n.running = 0;
        if (m.running) n.mag = 0;
      end
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  // Expected {EN, CAT, ANO, DIS, BLANK, DONE} for the position now on show.
  function automatic logic [5:0] model_phase(input cfg_t c, input mdl_t m);
    int p     = m.o_pos;
    int ano_s = c.cat + c.ipd;
    int dis_s = ano_s + c.ano + c.dly;
    int dis_e = dis_s + c.dis - 1;
    if (!m.o_running) return 6'b0;
    return {1'b1, p < c.cat, (p >= ano_s) && (p < ano_s + c.ano),
            (p >= dis_s) && (p <= dis_e), p <= dis_e + c.tail, p == dis_e};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rst_n, input logic ramp,
                               input logic sweep, input logic [4:0] target);
    enable = en; Resetn = rst_n; ramping = ramp; ch_sweeping = sweep; mag_target = target;
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_a = model_step(cfg_a, mdl_a);
    mdl_b = model_step(cfg_b, mdl_b);
    @(negedge clk);
    checkOutput("A.phase", 32'({bus_a.EN_ST, bus_a.CAT_ST, bus_a.ANO_ST, bus_a.DIS_ST,
                                bus_a.BLANK_EMG, bus_a.pulse_done}), 32'(model_phase(cfg_a, mdl_a)));
    checkOutput("A.mag", 32'(bus_a.MAG_ST), 32'(mdl_a.mag));
    checkOutput("A.chsel", 32'({bus_a.CH_SEL_U_ST, bus_a.CH_SEL_D_ST}),
                32'(mdl_a.ch * 4 + (mdl_a.ch + 1) % cfg_a.nch));
    checkOutput("B.phase", 32'({bus_b.EN_ST, bus_b.CAT_ST, bus_b.ANO_ST, bus_b.DIS_ST,
                                bus_b.BLANK_EMG, bus_b.pulse_done}), 32'(model_phase(cfg_b, mdl_b)));
    checkOutput("B.mag", 32'(bus_b.MAG_ST), 32'(mdl_b.mag));
    checkOutput("B.chsel", 32'({bus_b.CH_SEL_U_ST, bus_b.CH_SEL_D_ST}),
                32'(mdl_b.ch * 4 + (mdl_b.ch + 1) % cfg_b.nch));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the default-timing channel reaches the given pulse position.
  task automatic runToPos(input int pos);
    for (int i = 0; i < 2 * cfg_a.period; i++) begin
      if (mdl_a.running && mdl_a.pos == pos) break;
      tick();
    end
    checkOutput("A.reach_pos", 32'(mdl_a.pos), 32'(pos));
  endtask

  initial begin
    cfg_a = '{period:500, cat:150, ipd:10, ano:150, dly:1, dis:5, tail:20,
              ppc:5, nch:4, step:1};
    cfg_b = '{period:40, cat:6, ipd:0, ano:6, dly:0, dis:3, tail:4,
              ppc:2, nch:3, step:3};
    mdl_a = mdl_clear();
    mdl_b = mdl_clear();

    // Reset, then a steady train at magnitude 9
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd9);
    runCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
    runCycles(1000);

    // Drop enable during the anodic phase; the pulse finishes, then IDLE
    runToPos(200);
    enable = 1'b0;
    runCycles(800);

    // Ramp from 0 with sweeping; target changes mid-pulse, later at random
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
    for (int i = 0; i < 22 * 500; i++) begin
      if (i == 4 * 500 + 100) mag_target = 5'd1;
      else if (i > 6 * 500 && $urandom_range(0, 399) == 0) mag_target = 5'($urandom_range(0, 31));
      tick();
    end

    // Reset during the cathodic phase with enable held high
    runToPos(50);
    Resetn = 1'b0;
    runCycles(2);
    Resetn = 1'b1;
    runCycles(1200);

    // Random segments of all controls, with occasional short resets
    for (int s = 0; s < 40; s++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'b1, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 9) == 0) begin
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
      end
      runCycles(100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
